// File: rtl/datapath_pkg.sv
// Shared types and helpers for the R/I-type integer datapath.
package datapath_pkg;

  localparam int unsigned XLEN_DEF  = 64;
  localparam int unsigned NREG_DEF  = 32;
  localparam int unsigned IMM_W_DEF = 12;
  // Working width of sext(); datapaths up to this width are supported.
  localparam int unsigned SEXT_W    = 128;

  typedef enum logic [3:0] {
    AluAnd = 4'b0000,
    AluOr  = 4'b0001,
    AluAdd = 4'b0010,
    AluXor = 4'b0011,
    AluSub = 4'b0110,
    AluSlt = 4'b0111,
    AluSll = 4'b1000,
    AluSrl = 4'b1001,
    AluSra = 4'b1010,
    AluNor = 4'b1100
  } alu_op_e;

  // Sign-extend the low 'width' bits of val to SEXT_W bits.
  function automatic logic [SEXT_W-1:0] sext(input logic [SEXT_W-1:0] val,
                                             input int unsigned       width);
    logic [SEXT_W-1:0] shl;
    shl = val << (SEXT_W - width);
    return $signed(shl) >>> (SEXT_W - width);
  endfunction

endpackage

// File: rtl/alu_xlen.sv
// Combinational integer ALU: logic, add/sub with signed overflow, signed compare and shifts.
module alu_xlen
  import datapath_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [3:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_result,
  output logic            o_zero,
  output logic            o_overflow
);

  localparam int unsigned SHW = $clog2(XLEN);

  logic [SHW-1:0]  w_shamt;
  logic [XLEN-1:0] w_sum;
  logic [XLEN-1:0] w_diff;

  assign w_shamt = i_b[SHW-1:0];
  assign w_sum   = i_a + i_b;
  assign w_diff  = i_a - i_b;

  always_comb begin
    o_result   = '0;
    o_overflow = 1'b0;
    case (i_op)
      AluAnd: o_result = i_a & i_b;
      AluOr:  o_result = i_a | i_b;
      AluXor: o_result = i_a ^ i_b;
      AluNor: o_result = ~(i_a | i_b);
      AluAdd: begin
        o_result   = w_sum;
        o_overflow = (i_a[XLEN-1] == i_b[XLEN-1]) && (w_sum[XLEN-1] != i_a[XLEN-1]);
      end
      AluSub: begin
        o_result   = w_diff;
        o_overflow = (i_a[XLEN-1] != i_b[XLEN-1]) && (w_diff[XLEN-1] != i_a[XLEN-1]);
      end
      AluSlt: o_result = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      AluSll: o_result = i_a << w_shamt;
      AluSrl: o_result = i_a >> w_shamt;
      AluSra: o_result = XLEN'($signed(i_a) >>> w_shamt);
      default: o_result = '0;
    endcase
  end

  assign o_zero = (o_result == '0);

endmodule

// File: rtl/datapath_r_i_pipe.sv
// Two-stage R/I-type datapath: regfile, operand mux with WB->EX bypass, ALU and a
// handshaked EX/WB register that commits to the regfile on retire.
module datapath_r_i_pipe
  import datapath_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned NREG  = NREG_DEF,
  parameter int unsigned IMM_W = IMM_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [$clog2(NREG)-1:0] register_1,
  input  logic [$clog2(NREG)-1:0] register_2,
  input  logic [$clog2(NREG)-1:0] write_reg,
  input  logic                    ALUSrc,
  input  logic [IMM_W-1:0]        imm,
  input  logic                    RegWrite,
  input  logic [3:0]              ALU_CO,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         ALU_result,
  output logic                    zero,
  output logic                    overflow,
  output logic [$clog2(NREG)-1:0] out_rd
);

  localparam int unsigned REG_AW = $clog2(NREG);

  logic [XLEN-1:0]   r_regs [NREG];
  logic              r_out_valid;
  logic              r_out_we;
  logic [XLEN-1:0]   r_result;
  logic              r_zero;
  logic              r_ovf;
  logic [REG_AW-1:0] r_out_rd;

  logic              w_accept;
  logic              w_retire;
  logic              w_byp;
  logic [XLEN-1:0]   w_a;
  logic [XLEN-1:0]   w_rs2;
  logic [XLEN-1:0]   w_b;
  logic [XLEN-1:0]   w_imm_ext;
  logic [XLEN-1:0]   w_alu_res;
  logic              w_alu_zero;
  logic              w_alu_ovf;

  assign in_ready = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_retire = r_out_valid && out_ready;
  assign w_byp    = r_out_valid && r_out_we;

  assign w_imm_ext = XLEN'(sext(SEXT_W'(imm), IMM_W));

  // Bypass reads the not-yet-committed result, so a dependent op never needs a bubble.
  always_comb begin
    w_a = r_regs[register_1];
    if (register_1 == '0) begin
      w_a = '0;
    end else if (w_byp && (r_out_rd == register_1)) begin
      w_a = r_result;
    end
    w_rs2 = r_regs[register_2];
    if (register_2 == '0) begin
      w_rs2 = '0;
    end else if (w_byp && (r_out_rd == register_2)) begin
      w_rs2 = r_result;
    end
    w_b = ALUSrc ? w_imm_ext : w_rs2;
  end

  alu_xlen #(
    .XLEN(XLEN)
  ) u_alu (
    .i_op      (ALU_CO),
    .i_a       (w_a),
    .i_b       (w_b),
    .o_result  (w_alu_res),
    .o_zero    (w_alu_zero),
    .o_overflow(w_alu_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_we    <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_rd    <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_we    <= RegWrite;
      r_result    <= w_alu_res;
      r_zero      <= w_alu_zero;
      r_ovf       <= w_alu_ovf;
      r_out_rd    <= write_reg;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_retire && r_out_we && (r_out_rd != '0)) begin
      r_regs[r_out_rd] <= r_result;
    end
  end

  assign out_valid  = r_out_valid;
  assign ALU_result = r_result;
  assign zero       = r_zero;
  assign overflow   = r_ovf;
  assign out_rd     = r_out_rd;

endmodule

// File: tb/tb_datapath_r_i_pipe.sv
// Self-checking bench for datapath_r_i_pipe: directed scenarios plus randomized ops
// against an in-order architectural reference model.
module tb_datapath_r_i_pipe;

  localparam logic [3:0] OP_AND = 4'b0000, OP_OR  = 4'b0001, OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011, OP_SUB = 4'b0110, OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b1000, OP_SRL = 4'b1001, OP_SRA = 4'b1010;
  localparam logic [3:0] OP_NOR = 4'b1100;

  logic        clk, rst_n, in_valid, in_ready, ALUSrc, RegWrite;
  logic [4:0]  register_1, register_2, write_reg, out_rd;
  logic [11:0] imm;
  logic [3:0]  ALU_CO;
  logic        out_valid, out_ready, zero, overflow;
  logic [63:0] ALU_result;

  logic [63:0] m_rf [32];
  int          n_checks = 0;
  int          n_pass   = 0;

  datapath_r_i_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .register_1(register_1),
    .register_2(register_2),
    .write_reg (write_reg),
    .ALUSrc    (ALUSrc),
    .imm       (imm),
    .RegWrite  (RegWrite),
    .ALU_CO    (ALU_CO),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALU_result(ALU_result),
    .zero      (zero),
    .overflow  (overflow),
    .out_rd    (out_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void ref_alu(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] r, output logic o);
    logic signed [64:0] wide;
    o = 1'b0;
    case (op)
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_NOR: r = ~(a | b);
      OP_ADD, OP_SUB: begin
        if (op == OP_ADD) wide = $signed({a[63], a}) + $signed({b[63], b});
        else              wide = $signed({a[63], a}) - $signed({b[63], b});
        r = wide[63:0];
        o = (wide > 65'sh0_7FFF_FFFF_FFFF_FFFF) || (wide < 65'sh1_8000_0000_0000_0000);
      end
      OP_SLT: r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
      OP_SLL: r = a << b[5:0];
      OP_SRL: r = a >> b[5:0];
      OP_SRA: r = $signed(a) >>> b[5:0];
      default: r = 64'd0;
    endcase
  endfunction

  // Computes the architectural result, then presents the op until it is accepted.
  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic src, input logic [11:0] im, input logic we,
                       input logic [3:0] op, output logic [63:0] e_res, output logic e_ovf);
    logic [63:0] a, b;
    bit acc;
    a = (rs1 == 0) ? 64'd0 : m_rf[rs1];
    b = src ? {{52{im[11]}}, im} : ((rs2 == 0) ? 64'd0 : m_rf[rs2]);
    ref_alu(op, a, b, e_res, e_ovf);
    if (we && rd != 0) m_rf[rd] = e_res;
    register_1 = rs1; register_2 = rs2; write_reg = rd;
    ALUSrc = src; imm = im; RegWrite = we; ALU_CO = op;
    in_valid = 1'b1;
    acc = 1'b0;
    for (int c = 0; c < 50 && !acc; c++) begin
      @(negedge clk); #1;
      acc = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_checks++;
      $display("FAIL accept_timeout: in_ready got 0 expected 1 within 50 cycles");
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic read_reg(input logic [4:0] k, output logic [63:0] e);
    logic o;
    issue(k, 5'd0, 5'd0, 1'b0, 12'h000, 1'b0, OP_OR, e, o);
  endtask

  task automatic test_reset();
    logic [63:0] e;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    register_1 = 0; register_2 = 0; write_reg = 0; ALUSrc = 0; imm = 0; RegWrite = 0;
    ALU_CO = OP_AND;
    for (int i = 0; i < 32; i++) m_rf[i] = 64'd0;
    #12;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b expected 0", out_valid);
    else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b expected 1", in_ready);
    else n_pass++;
    n_checks++; if (ALU_result !== 64'd0) $display("FAIL rst_result: got %h expected 0", ALU_result);
    else n_pass++;
    n_checks++; if (zero !== 1'b0) $display("FAIL rst_zero: got %b expected 0", zero);
    else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL rst_ovf: got %b expected 0", overflow);
    else n_pass++;
    n_checks++; if (out_rd !== 5'd0) $display("FAIL rst_out_rd: got %0d expected 0", out_rd);
    else n_pass++;
    #10 rst_n = 1'b1;
    idle(1);
    for (int k = 0; k < 32; k++) begin
      read_reg(5'(k), e);
      n_checks++;
      if (ALU_result !== 64'd0) $display("FAIL rst_reg%0d: got %h expected 0", k, ALU_result);
      else n_pass++;
    end
  endtask

  task automatic test_itype();
    logic [63:0] e; logic o;
    issue(5'd0, 5'd0, 5'd1, 1'b1, 12'hFFB, 1'b1, OP_ADD, e, o);
    n_checks++;
    if (ALU_result !== 64'hFFFF_FFFF_FFFF_FFFB)
      $display("FAIL addi_result: got %h expected FFFFFFFFFFFFFFFB", ALU_result);
    else n_pass++;
    n_checks++; if (out_rd !== 5'd1) $display("FAIL addi_rd: got %0d expected 1", out_rd);
    else n_pass++;
    idle(2);
    read_reg(5'd1, e);
    n_checks++;
    if (ALU_result !== 64'hFFFF_FFFF_FFFF_FFFB)
      $display("FAIL addi_commit: got %h expected FFFFFFFFFFFFFFFB", ALU_result);
    else n_pass++;
  endtask

  task automatic test_bypass();
    logic [63:0] e; logic o;
    idle(1);
    issue(5'd0, 5'd0, 5'd1, 1'b1, 12'd7, 1'b1, OP_ADD, e, o);
    n_checks++; if (in_ready !== 1'b1) $display("FAIL byp_in_ready: got %b expected 1", in_ready);
    else n_pass++;
    issue(5'd1, 5'd1, 5'd2, 1'b0, 12'd0, 1'b1, OP_ADD, e, o);
    n_checks++; if (ALU_result !== 64'd14) $display("FAIL byp_result: got %h expected 14", ALU_result);
    else n_pass++;
    idle(2);
    read_reg(5'd2, e);
    n_checks++; if (ALU_result !== 64'd14) $display("FAIL byp_commit: got %h expected 14", ALU_result);
    else n_pass++;
  endtask

  task automatic test_stall();
    logic [63:0] e, e2; logic o;
    out_ready = 1'b1;
    idle(2);
    out_ready = 1'b0;
    issue(5'd0, 5'd0, 5'd5, 1'b1, 12'd100, 1'b1, OP_ADD, e, o);
    n_checks++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready: got %b expected 0", in_ready);
    else n_pass++;
    fork
      issue(5'd5, 5'd0, 5'd6, 1'b1, 12'd1, 1'b1, OP_ADD, e2, o);
      begin
        repeat (2) begin
          @(negedge clk);
          n_checks++;
          if (ALU_result !== 64'd100) $display("FAIL stall_hold: got %h expected 100", ALU_result);
          else n_pass++;
          n_checks++; if (out_rd !== 5'd5) $display("FAIL stall_rd: got %0d expected 5", out_rd);
          else n_pass++;
        end
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    n_checks++; if (ALU_result !== 64'd101) $display("FAIL stall_next: got %h expected 101", ALU_result);
    else n_pass++;
    idle(2);
    read_reg(5'd5, e);
    n_checks++; if (ALU_result !== 64'd100) $display("FAIL stall_commit5: got %h expected 100", ALU_result);
    else n_pass++;
    read_reg(5'd6, e);
    n_checks++; if (ALU_result !== 64'd101) $display("FAIL stall_commit6: got %h expected 101", ALU_result);
    else n_pass++;
  endtask

  task automatic test_ovf_zero();
    logic [63:0] e; logic o;
    issue(5'd0, 5'd0, 5'd4, 1'b1, 12'hFFF, 1'b1, OP_ADD, e, o);
    issue(5'd4, 5'd0, 5'd4, 1'b1, 12'h001, 1'b1, OP_SRL, e, o);
    issue(5'd4, 5'd0, 5'd7, 1'b1, 12'h001, 1'b1, OP_ADD, e, o);
    n_checks++;
    if (ALU_result !== 64'h8000_0000_0000_0000)
      $display("FAIL ovf_result: got %h expected 8000000000000000", ALU_result);
    else n_pass++;
    n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b expected 1", overflow);
    else n_pass++;
    issue(5'd3, 5'd3, 5'd8, 1'b0, 12'h000, 1'b1, OP_SUB, e, o);
    n_checks++; if (zero !== 1'b1) $display("FAIL zero_flag: got %b expected 1", zero);
    else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL sub_ovf: got %b expected 0", overflow);
    else n_pass++;
  endtask

  task automatic test_r0_and_reset();
    logic [63:0] e; logic o;
    issue(5'd0, 5'd0, 5'd0, 1'b1, 12'd5, 1'b1, OP_ADD, e, o);
    n_checks++; if (ALU_result !== 64'd5) $display("FAIL r0_result: got %h expected 5", ALU_result);
    else n_pass++;
    idle(2);
    read_reg(5'd0, e);
    n_checks++; if (ALU_result !== 64'd0) $display("FAIL r0_stays: got %h expected 0", ALU_result);
    else n_pass++;
    idle(2);
    out_ready = 1'b0;
    issue(5'd0, 5'd0, 5'd9, 1'b1, 12'd33, 1'b1, OP_ADD, e, o);
    n_checks++; if (out_valid !== 1'b1) $display("FAIL mid_pre_valid: got %b expected 1", out_valid);
    else n_pass++;
    #2 rst_n = 1'b0;
    for (int i = 0; i < 32; i++) m_rf[i] = 64'd0;
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL mid_rst_valid: got %b expected 0", out_valid);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle(2);
    read_reg(5'd9, e);
    n_checks++; if (ALU_result !== 64'd0) $display("FAIL mid_rst_nowrite: got %h expected 0", ALU_result);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [3:0] ops [12];
    logic [63:0] e; logic o;
    bit stop;
    ops = '{OP_AND, OP_OR, OP_ADD, OP_XOR, OP_SUB, OP_SLT, OP_SLL, OP_SRL, OP_SRA, OP_NOR,
            4'b0100, 4'b1111};
    stop = 1'b0;
    for (int i = 1; i < 8; i++) issue(5'd0, 5'd0, 5'(i), 1'b1, 12'($urandom), 1'b1, OP_ADD, e, o);
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          issue(5'($urandom_range(7)), 5'($urandom_range(7)), 5'($urandom_range(7)),
                1'($urandom), 12'($urandom), 1'($urandom_range(3) != 0),
                ops[$urandom_range(11)], e, o);
          n_checks++; if (out_valid !== 1'b1) $display("FAIL rnd_valid: got %b expected 1", out_valid);
          else n_pass++;
          n_checks++; if (ALU_result !== e) $display("FAIL rnd_result: got %h expected %h", ALU_result, e);
          else n_pass++;
          n_checks++; if (overflow !== o) $display("FAIL rnd_ovf: got %b expected %b", overflow, o);
          else n_pass++;
          n_checks++;
          if (zero !== (e == 64'd0)) $display("FAIL rnd_zero: got %b expected %b", zero, e == 64'd0);
          else n_pass++;
          n_checks++;
          if (out_rd !== write_reg) $display("FAIL rnd_rd: got %0d expected %0d", out_rd, write_reg);
          else n_pass++;
          if ($urandom_range(3) == 0) idle(1);
        end
        stop = 1'b1;
      end
      begin
        while (!stop) begin
          @(negedge clk);
          if (!stop) out_ready = ($urandom_range(3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    idle(3);
    for (int k = 1; k < 8; k++) begin
      logic [63:0] exp_v;
      exp_v = m_rf[k];
      read_reg(5'(k), e);
      n_checks++;
      if (ALU_result !== exp_v) $display("FAIL rnd_reg%0d: got %h expected %h", k, ALU_result, exp_v);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_itype();
    test_bypass();
    test_stall();
    test_ovf_zero();
    test_r0_and_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
